// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, minimum divider and receiver FSM states.
package uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned UART_DIV_MIN = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_rx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// 16-bit baud down-counter with load and zero flag; holds at zero until reloaded.
module uart_baud_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_zero
);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    assign o_zero = (r_cnt == 16'd0);

endmodule

// File: rtl/uart_rx_modport.sv
// UART receiver: 8 data bits, optional even parity, 1 or 2 stop bits, programmable divider.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on rx_i.
module uart_rx_modport
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   stop_bits_i,
    input  logic                   parity_bit_i,
    input  logic [15:0]            baud_div_i,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    output logic                   err_o
);

    logic w_line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_i};
        end
    end

    assign w_line = r_sync[1];
`else
    assign w_line = rx_i;
`endif

    uart_rx_state_t         r_state, w_state_nxt;
    logic [15:0]            w_div, r_div, w_load_val;
    logic [UART_DATA_W-1:0] r_shift, r_data;
    logic [2:0]             r_bit_idx;
    logic                   r_stop_left, r_par_en, r_par, r_par_err, r_fe, r_armed;
    logic                   r_valid, r_err;
    logic                   w_load, w_zero, w_start, w_done, w_stop_fe, w_bad;

    assign w_div     = (baud_div_i < 16'(UART_DIV_MIN)) ? 16'(UART_DIV_MIN) : baud_div_i;
    assign w_stop_fe = r_fe | ~w_line;
    assign w_bad     = w_stop_fe | r_par_err;

    uart_baud_cnt u_baud_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = r_div - 16'd1;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_armed && !w_line) begin
                    w_state_nxt = StStart;
                    w_start     = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = (w_div >> 1) - 16'd1;
                end
            end
            StStart: begin
                if (w_zero) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_line ? StIdle : StData;
                end
            end
            StData: begin
                if (w_zero) begin
                    w_load = 1'b1;
                    if (r_bit_idx == 3'(UART_DATA_W - 1)) begin
                        w_state_nxt = r_par_en ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (w_zero) begin
                    w_load      = 1'b1;
                    w_state_nxt = StStop;
                end
            end
            StStop: begin
                if (w_zero) begin
                    w_load = 1'b1;
                    if (!r_stop_left) begin
                        w_state_nxt = StIdle;
                        w_done      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (!en_i) begin
            w_state_nxt = StIdle;
            w_start     = 1'b0;
            w_done      = 1'b0;
            w_load      = 1'b0;
        end
    end

    // Frame settings are captured at start so mid-frame config writes cannot corrupt it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_div       <= 16'(UART_DIV_MIN);
            r_shift     <= '0;
            r_data      <= '0;
            r_bit_idx   <= 3'd0;
            r_stop_left <= 1'b0;
            r_par_en    <= 1'b0;
            r_par       <= 1'b0;
            r_par_err   <= 1'b0;
            r_fe        <= 1'b0;
            r_armed     <= 1'b1;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (r_state == StIdle && w_line) begin
                r_armed <= 1'b1;
            end
            if (w_start) begin
                r_div       <= w_div;
                r_par_en    <= parity_bit_i;
                r_stop_left <= stop_bits_i;
                r_bit_idx   <= 3'd0;
                r_par       <= 1'b0;
                r_par_err   <= 1'b0;
                r_fe        <= 1'b0;
            end
            if (en_i && w_zero) begin
                case (r_state)
                    StData: begin
                        r_shift   <= {w_line, r_shift[UART_DATA_W-1:1]};
                        r_par     <= r_par ^ w_line;
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    StParity: r_par_err <= r_par ^ w_line;
                    StStop: begin
                        r_fe        <= w_stop_fe;
                        r_stop_left <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // A framing error leaves the line possibly low; wait for high before re-arming.
            if (w_done) begin
                if (w_bad) begin
                    r_err <= 1'b1;
                    if (w_stop_fe) begin
                        r_armed <= 1'b0;
                    end
                end else begin
                    r_valid <= 1'b1;
                    r_data  <= r_shift;
                end
            end
        end
    end

    assign rx_data_o  = r_data;
    assign rx_valid_o = r_valid;
    assign err_o      = r_err;

endmodule

// File: tb/tb_uart_rx_modport.sv
// Scoreboard bench for uart_rx_modport: frames push expected pulses, a negedge monitor pops them.
module tb_uart_rx_modport;

`ifdef UART_RX_SYNC_EN
    localparam int unsigned SYNC_LAT = 2;
`else
    localparam int unsigned SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        stop_bits_i;
    logic        parity_bit_i;
    logic [15:0] baud_div_i;
    logic        rx_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        err_o;

    uart_rx_modport dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .stop_bits_i  (stop_bits_i),
        .parity_bit_i (parity_bit_i),
        .baud_div_i   (baud_div_i),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_err;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // cyc+1 is the edge at which a downstream consumer captures the pulse.
    always @(negedge clk) begin
        if (rx_valid_o || err_o) begin
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", {30'd0, err_o, rx_valid_o}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("valid", {31'd0, rx_valid_o}, {31'd0, ~mon_e.is_err});
                check_val("err", {31'd0, err_o}, {31'd0, mon_e.is_err});
                check_val("data", {24'd0, rx_data_o}, {24'd0, mon_e.data});
                check_val("timing", cyc + 1, mon_e.at);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned nprog, input bit par,
                              input bit par_flip, input bit two_stop, input bit bad_stop2);
        int unsigned eff, h, t0, nsamp;
        bit          bad;
        exp_t        e;
        eff          = (nprog < 4) ? 4 : nprog;
        h            = eff / 2;
        baud_div_i   = 16'(nprog);
        parity_bit_i = par;
        stop_bits_i  = two_stop;
        t0           = cyc + 1 + SYNC_LAT;
        nsamp        = 8 + (par ? 1 : 0) + 1 + (two_stop ? 1 : 0);
        bad          = (par && par_flip) || (two_stop && bad_stop2);
        e.is_err     = bad;
        e.data       = bad ? last_good : d;
        e.at         = t0 + h + nsamp * eff + 1;
        sb.push_back(e);
        if (!bad) last_good = d;
        rx_i = 1'b0;
        tick(eff);
        for (int k = 0; k < 8; k++) begin
            rx_i = d[k];
            tick(eff);
        end
        if (par) begin
            rx_i = (^d) ^ par_flip;
            tick(eff);
        end
        rx_i = 1'b1;
        tick(eff);
        if (two_stop) begin
            rx_i = ~bad_stop2;
            tick(eff);
        end
        rx_i = 1'b1;
    endtask

    initial begin
        logic [7:0] ab;
        rst_n        = 1'b1;
        en_i         = 1'b1;
        rx_i         = 1'b1;
        baud_div_i   = 16'd16;
        stop_bits_i  = 1'b0;
        parity_bit_i = 1'b0;
        tick(3);
        check_val("rst_data", {24'd0, rx_data_o}, 32'd0);
        check_val("rst_valid", {31'd0, rx_valid_o}, 32'd0);
        check_val("rst_err", {31'd0, err_o}, 32'd0);
        rst_n = 1'b0;
        tick(5);

        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(20);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(20);
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(20);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(20);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(20);

        // Short low glitch must be rejected by the mid-start sample.
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(40);
        check_val("glitch_data", {24'd0, rx_data_o}, {24'd0, last_good});

        // Enable dropped in the middle of data bit 3, held off until the line idles.
        ab           = 8'h55;
        baud_div_i   = 16'd16;
        parity_bit_i = 1'b0;
        stop_bits_i  = 1'b0;
        rx_i         = 1'b0;
        tick(16);
        for (int k = 0; k < 8; k++) begin
            rx_i = ab[k];
            if (k == 3) begin
                tick(8);
                en_i = 1'b0;
                tick(8);
            end else begin
                tick(16);
            end
        end
        rx_i = 1'b1;
        tick(20);
        en_i = 1'b1;
        tick(5);
        check_val("abort_data", {24'd0, rx_data_o}, {24'd0, last_good});
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(20);

        // Reset in the middle of a frame clears everything.
        rx_i = 1'b0;
        tick(16);
        tick(26);
        rst_n = 1'b1;
        rx_i  = 1'b1;
        tick(2);
        check_val("midrst_data", {24'd0, rx_data_o}, 32'd0);
        check_val("midrst_valid", {31'd0, rx_valid_o}, 32'd0);
        check_val("midrst_err", {31'd0, err_o}, 32'd0);
        rst_n     = 1'b0;
        last_good = 8'h00;
        tick(20);

        // Divider below the minimum, frames back to back.
        send_frame(8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(20);

        check_val("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
